alu_operand_pipe: RTL

Parametrised, registered operand-selection stage for the pipelined datapath. It supersedes the plain ALU-source and write-back 2:1 selectors. It resolves EX/MEM and MEM/WB forwarding, including the write-back data choice, then applies the immediate select. The resulting ALU operands and store data are captured in an ID/EX-style pipeline register with stall and flush control.

---
 rtl/alu_operand_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_operand_pipe.sv
// Operand-selection stage: resolves EX/MEM and MEM/WB forwarding, applies the
// immediate select, and registers operands/store data with stall and flush.
module alu_operand_pipe #(
  parameter int WIDTH    = 32,
  parameter int RADDR_W  = 5,
  parameter int ZERO_REG = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [WIDTH-1:0]   imm,
  input  logic               alu_src,
  input  logic               exmem_wr,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_alu,
  input  logic               memwb_wr,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic               memwb_mem_to_reg,
  input  logic [WIDTH-1:0]   memwb_rdata,
  input  logic [WIDTH-1:0]   memwb_alu,
  output logic               out_valid,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   store_data,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_EX = 2'b10
  } fwd_e;

  localparam logic [RADDR_W-1:0] ZERO_ADDR = RADDR_W'(ZERO_REG);

  // EX/MEM is checked first so the younger result always wins.
  function automatic fwd_e fwd_sel(
    input logic [RADDR_W-1:0] src,
    input logic               ex_wr,
    input logic [RADDR_W-1:0] ex_rd,
    input logic               wb_wr,
    input logic [RADDR_W-1:0] wb_rd
  );
    if (src == ZERO_ADDR)              return FWD_RF;
    else if (ex_wr && (ex_rd == src))  return FWD_EX;
    else if (wb_wr && (wb_rd == src))  return FWD_WB;
    else                               return FWD_RF;
  endfunction

  logic [WIDTH-1:0] wb_val;
  logic [WIDTH-1:0] fa;
  logic [WIDTH-1:0] fb;
  fwd_e             sel_a;
  fwd_e             sel_b;

  always_comb begin
    wb_val = memwb_mem_to_reg ? memwb_rdata : memwb_alu;
    sel_a  = fwd_sel(rs_addr, exmem_wr, exmem_rd, memwb_wr, memwb_rd);
    sel_b  = fwd_sel(rt_addr, exmem_wr, exmem_rd, memwb_wr, memwb_rd);

    unique case (sel_a)
      FWD_EX:  fa = exmem_alu;
      FWD_WB:  fa = wb_val;
      default: fa = rs_data;
    endcase

    unique case (sel_b)
      FWD_EX:  fb = exmem_alu;
      FWD_WB:  fb = wb_val;
      default: fb = rt_data;
    endcase
  end

  logic             out_valid_d,  out_valid_q;
  logic [WIDTH-1:0] op_a_d,       op_a_q;
  logic [WIDTH-1:0] op_b_d,       op_b_q;
  logic [WIDTH-1:0] store_data_d, store_data_q;
  fwd_e             fwd_a_d,      fwd_a_q;
  fwd_e             fwd_b_d,      fwd_b_q;

  always_comb begin
    // NOTE: every output of this block gets a default first (here: hold), so
    // no path leaves a variable unassigned and no latch is inferred.
    out_valid_d  = out_valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    store_data_d = store_data_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      op_a_d       = '0;
      op_b_d       = '0;
      store_data_d = '0;
      fwd_a_d      = FWD_RF;
      fwd_b_d      = FWD_RF;
    end else if (!stall) begin
      // Data loads even for a bubble; only out_valid marks it invalid.
      out_valid_d  = in_valid;
      op_a_d       = fa;
      op_b_d       = alu_src ? imm : fb;
      store_data_d = fb;
      fwd_a_d      = sel_a;
      fwd_b_d      = sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of its _d input, independent of statement order.
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      store_data_q <= '0;
      fwd_a_q      <= FWD_RF;
      fwd_b_q      <= FWD_RF;
    end else begin
      out_valid_q  <= out_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      store_data_q <= store_data_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign store_data = store_data_q;
  assign fwd_a      = fwd_a_q;
  assign fwd_b      = fwd_b_q;

endmodule
